// File: rtl/sys_array_feeder.sv
// Feeds a vector of signed pixels into a systolic array, waits out the array
// latency, captures the row results and reports the arg-max class.
module sys_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 10,
  parameter int ARRAY_L    = 30,
  parameter int LATENCY    = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [DATA_WIDTH-1:0]  s_data,
  input  logic                          s_last,
  output logic signed [DATA_WIDTH-1:0]  array_input_data [0:ARRAY_L-1],
  output logic [15:0]                   array_a_l,
  input  logic signed [2*DATA_WIDTH-1:0] array_output_data [0:ARRAY_W-1],
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [2*DATA_WIDTH-1:0] m_result [0:ARRAY_W-1],
  output logic [$clog2(ARRAY_W)-1:0]    m_class,
  output logic                          busy
);

  localparam int CNT_W  = $clog2(ARRAY_L);
  localparam int IDX_W  = $clog2(ARRAY_W);
  localparam int HOLD_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0]  LAST_COL  = CNT_W'(ARRAY_L - 1);
  localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(ARRAY_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LATENCY - 1);

  localparam logic [2:0] S_FILL    = 3'd0;
  localparam logic [2:0] S_HOLD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ARGMAX  = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  logic [2:0]                    r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [HOLD_W-1:0]             r_hold_cnt;
  logic [IDX_W-1:0]              r_arg_idx;
  logic [15:0]                   r_a_l;
  logic signed [DATA_WIDTH-1:0]  r_buf    [0:ARRAY_L-1];
  logic signed [2*DATA_WIDTH-1:0] r_result [0:ARRAY_W-1];
  logic signed [2*DATA_WIDTH-1:0] r_best;
  logic [IDX_W-1:0]              r_class;

  logic w_accept;
  logic w_close;

  assign s_ready  = (r_state == S_FILL);
  assign busy     = (r_state != S_FILL);
  assign m_valid  = (r_state == S_OUT);
  assign w_accept = s_valid && s_ready;
  assign w_close  = w_accept && (s_last || (r_cnt == LAST_COL));

  assign array_input_data = r_buf;
  assign array_a_l        = r_a_l;
  assign m_result         = r_result;
  assign m_class          = r_class;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FILL;
      r_cnt      <= '0;
      r_hold_cnt <= '0;
      r_arg_idx  <= '0;
      r_a_l      <= 16'(ARRAY_L);
      r_best     <= '0;
      r_class    <= '0;
      // NOTE: the buffer must be reset element by element because unwritten
      // columns are required to read 0; this forces flops, not a RAM macro.
      for (int i = 0; i < ARRAY_L; i++) r_buf[i] <= '0;
      for (int i = 0; i < ARRAY_W; i++) r_result[i] <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_buf[r_cnt] <= s_data;
            if (w_close) begin
              r_a_l      <= 16'(r_cnt) + 16'd1;
              r_cnt      <= '0;
              r_hold_cnt <= HOLD_INIT;
              r_state    <= S_HOLD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == '0) r_state <= S_CAPTURE;
          else                  r_hold_cnt <= r_hold_cnt - 1'b1;
        end
        S_CAPTURE: begin
          r_result  <= array_output_data;
          r_arg_idx <= '0;
          r_state   <= S_ARGMAX;
        end
        S_ARGMAX: begin
          // Strictly greater keeps the earliest row on ties.
          if ((r_arg_idx == '0) || (r_result[r_arg_idx] > r_best)) begin
            r_best  <= r_result[r_arg_idx];
            r_class <= r_arg_idx;
          end
          if (r_arg_idx == LAST_ROW) begin
            r_arg_idx <= '0;
            r_state   <= S_OUT;
          end else begin
            r_arg_idx <= r_arg_idx + 1'b1;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            for (int i = 0; i < ARRAY_L; i++) r_buf[i] <= '0;
            r_state <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Self-checking bench for sys_array_feeder: directed corner cases plus random
// vectors, checked against a plain-arithmetic model of buffer, latency and arg-max.
module tb_sys_array_feeder;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int AL  = 30;
  localparam int LAT = 40;

  logic clk = 1'b0;
  logic reset;
  logic s_valid, s_ready, s_last, m_valid, m_ready, busy;
  logic signed [DW-1:0]   s_data;
  logic signed [DW-1:0]   arr_in  [0:AL-1];
  logic [15:0]            array_a_l;
  logic signed [2*DW-1:0] arr_out [0:AW-1];
  logic signed [2*DW-1:0] m_result [0:AW-1];
  logic [$clog2(AW)-1:0]  m_class;

  int vec [AL];
  int row [AW];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  sys_array_feeder #(.DATA_WIDTH(DW), .ARRAY_W(AW), .ARRAY_L(AL), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .array_input_data(arr_in), .array_a_l(array_a_l), .array_output_data(arr_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_class(m_class),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < AW; i++) arr_out[i] = 16'(row[i]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  // Model: the first n elements hold the vector, the rest read 0.
  function automatic int buf_mismatches(input int n);
    int bad = 0;
    for (int k = 0; k < AL; k++)
      if (int'(arr_in[k]) != ((k < n) ? vec[k] : 0)) bad++;
    return bad;
  endfunction

  function automatic int res_mismatches();
    int bad = 0;
    for (int i = 0; i < AW; i++)
      if (int'(m_result[i]) != row[i]) bad++;
    return bad;
  endfunction

  function automatic int model_argmax();
    int best = row[0];
    int idx  = 0;
    for (int i = 1; i < AW; i++)
      if (row[i] > best) begin best = row[i]; idx = i; end
    return idx;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 200 && !s_ready; t++) begin @(posedge clk); #1; end
    if (!s_ready) check("s_ready_timeout", 0, 1);
  endtask

  task automatic send_beats(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(vec[i]);
      s_last  = with_last && (i == n - 1);
      wait_ready();
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_closed(input int n);
    check("a_l", array_a_l, n);
    check("s_ready_closed", s_ready, 0);
    check("busy_closed", busy, 1);
    check("buf_contents", buf_mismatches(n), 0);
  endtask

  task automatic await_result(input int m_delay);
    int t;
    int bad;
    int cls0;
    int exp_cls;
    exp_cls = model_argmax();
    t = 0;
    while (!m_valid && t < 300) begin @(posedge clk); #1; t++; end
    if (!m_valid) begin
      check("m_valid_timeout", 0, 1);
      return;
    end
    check("latency", cyc - acc_cyc, LAT + AW + 1);
    check("m_class", m_class, exp_cls);
    check("m_result", res_mismatches(), 0);
    bad  = 0;
    cls0 = int'(m_class);
    repeat (m_delay) begin
      @(posedge clk); #1;
      if (!m_valid || int'(m_class) != cls0 || res_mismatches() != 0 || s_ready) bad++;
    end
    check("out_stable", bad, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("s_ready_after_out", s_ready, 1);
    check("m_valid_drop", m_valid, 0);
    check("buf_cleared", buf_mismatches(0), 0);
  endtask

  initial begin
    int bad;
    int v31;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    for (int i = 0; i < AW; i++) row[i] = 0;

    // Reset state
    do_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_a_l", array_a_l, AL);
    check("rst_buf", buf_mismatches(0), 0);
    check("rst_m_class", m_class, 0);

    // Full vector 1..30, tie between rows 2 and 3
    for (int k = 0; k < AL; k++) vec[k] = k + 1;
    row = '{5, -3, 9, 9, 0, 0, 0, 0, 0, 0};
    send_beats(AL, 1'b1);
    check_closed(AL);
    await_result(0);

    // Short vector of 7s, negative rows, consumer stalls with a beat waiting
    for (int k = 0; k < 12; k++) vec[k] = 7;
    for (int i = 0; i < AW; i++) row[i] = -100;
    row[7] = -1;
    send_beats(12, 1'b1);
    check_closed(12);
    check("m_result7_before", 0, 0 + int'(m_result[7] != 0));
    s_valid = 1'b1; s_data = 8'sd55; s_last = 1'b1;
    await_result(20);
    check("m_result7", m_result[7], -1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    acc_cyc = cyc;
    vec[0] = 55;
    check_closed(1);
    await_result(1);

    // 31 beats without s_last: closes at 30, beat 31 waits for the handshake
    for (int k = 0; k < AL; k++) vec[k] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < AW; i++) row[i] = int'($urandom_range(0, 65535)) - 32768;
    send_beats(AL, 1'b0);
    check_closed(AL);
    v31 = int'($urandom_range(0, 255)) - 128;
    s_valid = 1'b1; s_data = DW'(v31); s_last = 1'b1;
    await_result(3);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    acc_cyc = cyc;
    vec[0] = v31;
    check_closed(1);
    await_result(0);

    // Reset in the fifth HOLD cycle abandons the vector
    for (int k = 0; k < 12; k++) vec[k] = k - 6;
    send_beats(12, 1'b1);
    check_closed(12);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("hold_rst_s_ready", s_ready, 1);
    check("hold_rst_busy", busy, 0);
    check("hold_rst_a_l", array_a_l, AL);
    check("hold_rst_buf", buf_mismatches(0), 0);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (m_valid || !s_ready) bad++;
    end
    check("hold_rst_no_valid", bad, 0);

    // Random vectors, lengths and row results (narrow range forces ties)
    for (int it = 0; it < 8; it++) begin
      int n;
      bit wl;
      n  = int'($urandom_range(1, AL));
      wl = (n < AL) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < AL; k++) vec[k] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < AW; i++)
        row[i] = (it % 2 == 0) ? int'($urandom_range(0, 8)) - 4
                               : int'($urandom_range(0, 65535)) - 32768;
      send_beats(n, wl);
      check_closed(n);
      await_result(int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
